wb_master_seq: RTL and testbench
================================

Name: wb_master_seq

Overview:
- Wishbone classic single-transfer bus master; the initiator end of the user-project Wishbone slave port.
- Converts a valid/ready command stream (from LA-driven test logic or an on-chip sequencer) into one Wishbone cycle per command and returns a valid/ready response.
- Drives cyc/stb/we/sel/adr/dat toward a slave and samples ack/dat.
- Includes an ack timeout so a dead slave cannot hang the bus.

Parameters:
- TIMEOUT_CYCLES, 255: maximum bus cycles to wait for ack. Legal range 1..65535.
- TO_W, 16: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  single clock; all logic on the rising edge.
- wb_rst_ni  in  1  synchronous reset, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid and ready are both high at an edge.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte lane select.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  32  read data. 0 for writes and timeouts.
- rsp_timeout_o  out  1  transfer aborted by timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte select.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_dat_i  in  32  Wishbone read data.
- busy_o  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - One clock, wb_clk_i.
  - Reset is synchronous and active-low on wb_rst_ni.
  - While wb_rst_ni=0 at an edge: FSM goes to IDLE and every output register clears. cyc, stb, we, sel, adr, dat, rsp_valid, rsp_dat, rsp_timeout and busy all read 0. cmd_ready_o=0 during reset and 1 from the first edge after reset release.
  - Reset mid-transfer: cyc/stb fall at that edge, the pending command and response are discarded, and no response is issued.
- All Wishbone outputs are registered; nothing on the bus side is combinational from inputs.
- FSM states:
  - IDLE:
    - cmd_ready_o=1; cyc=stb=0.
    - On cmd_valid_i, latch we/adr/dat/sel into the wbm_* registers, set cyc=stb=1, clear the timeout counter, go to BUS.
  - BUS:
    - cmd_ready_o=0; cyc=stb=1 and all wbm_* outputs held stable.
    - Counter increments each cycle with ack low.
    - Ack sampled high: drop cyc/stb at that edge, go to RESP with rsp_timeout=0. rsp_dat = wbm_dat_i for a read, 0 for a write.
    - Counter reaches TIMEOUT_CYCLES-1 with ack low: drop cyc/stb, go to RESP with rsp_timeout=1 and rsp_dat=0.
    - If ack and timeout expiry coincide, ack wins.
  - RESP:
    - rsp_valid_o=1; rsp_dat_o and rsp_timeout_o held stable until rsp_ready_i is sampled high.
    - At that edge rsp_valid_o goes to 0 and the FSM returns to IDLE.
    - rsp_ready_i already high on entry: RESP lasts exactly one cycle.
- Latency:
  - Command accepted at edge N: cyc/stb high from N to N+1.
  - Zero-wait slave (ack in the first bus cycle): rsp_valid high after edge N+1. Minimum command-to-response latency is 2 cycles.
  - Back-to-back commands: a new command can be accepted no sooner than the cycle after the response handshake. Minimum period is 3 cycles per transfer.
- Other rules:
  - wbm_ack_i is ignored in IDLE and RESP; stray acks have no effect.
  - No pipelined Wishbone mode: stb never deasserts while cyc is high.
  - cmd_*_i are don't-care when not accepted.
  - The timeout counter saturates and never wraps.
  - busy_o = (state != IDLE).

Test Plan:
- Reset: hold wb_rst_ni=0 for 3 cycles, then release -> all outputs 0 during reset; cmd_ready_o=1 on the first cycle after release.
- Write, zero-wait slave: cmd we=1 adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, slave acks in the first bus cycle -> wbm_* carry exactly those values for 1 cycle; then rsp_valid=1, rsp_dat=0, rsp_timeout=0.
- Read with 5 wait states: slave returns 0x1234_5678 on its ack, rsp_ready held low 3 cycles -> cyc high 6 cycles; rsp_valid stays 1 with rsp_dat=0x1234_5678 stable until the handshake; cmd_ready stays 0 throughout.
- Timeout: TIMEOUT_CYCLES=4, no ack -> cyc high exactly 4 cycles, then rsp_timeout=1 and rsp_dat=0. Next, ack asserted on the 4th cycle of a fresh command -> rsp_timeout=0 (ack wins).
- Reset mid-transfer: drive wb_rst_ni=0 on the 2nd bus cycle -> cyc/stb=0 at that edge; no rsp_valid after release; a following read completes normally.
- Stray ack and throughput: ack pulsed while in IDLE -> no response. Then 4 back-to-back reads to a zero-wait slave with rsp_ready tied high -> exactly 4 responses, one every 3 cycles, in order.

Source files
------------

// File: rtl/wb_master_seq.sv
// Wishbone classic single-transfer master: one bus cycle per valid/ready command,
// with a saturating ack timeout so a dead slave cannot hang the bus.
module wb_master_seq #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_timeout_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_dat_q, rsp_dat_d;
    logic            rsp_to_q, rsp_to_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    // Next-state and output-register logic for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_to_d    = rsp_to_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    cyc_d   = 1'b1;
                    cnt_d   = {TO_W{1'b0}};
                    state_d = S_BUS;
                end else begin
                    cyc_d = 1'b0;
                end
            end
            S_BUS: begin
                // Ack is checked first so it wins over a coincident expiry.
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_to_d    = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0000_0000 : wbm_dat_i;
                    state_d     = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_to_d    = 1'b1;
                    rsp_dat_d   = 32'h0000_0000;
                    state_d     = S_RESP;
                end else if (cnt_q != TO_MAX) begin
                    cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            adr_q       <= 32'h0000_0000;
            dat_q       <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0000_0000;
            rsp_to_q    <= 1'b0;
            cnt_q       <= {TO_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_to_q    <= rsp_to_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready_o   = ready_q;
    assign busy_o        = busy_q;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = we_q;
    assign wbm_sel_o     = sel_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_dat_o     = dat_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_timeout_o = rsp_to_q;

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed self-checking bench for wb_master_seq: a default-timeout instance (a)
// and a TIMEOUT_CYCLES=4 instance (b) sharing clock, reset and command payload.
module tb_wb_master_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic [31:0] slv_dat;

    logic        a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready, a_rsp_to;
    logic [31:0] a_rsp_dat;
    logic        a_cyc, a_stb, a_we, a_ack, a_busy, a_ack_drv, a_zw;
    logic [3:0]  a_sel;
    logic [31:0] a_adr, a_dat, a_slv_dat;

    logic        b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_rsp_to;
    logic [31:0] b_rsp_dat;
    logic        b_cyc, b_stb, b_we, b_ack, b_busy;
    logic [3:0]  b_sel;
    logic [31:0] b_adr, b_dat;

    int n_checks;
    int n_errors;
    int cycle;
    logic        mon_en;
    logic [31:0] rsp_log[$];
    int          rsp_cyc[$];

    // Zero-wait slave model: acks whenever strobed and returns a function of the address.
    assign a_ack     = a_zw ? (a_cyc & a_stb) : a_ack_drv;
    assign a_slv_dat = a_zw ? (a_adr ^ 32'hA5A5_0000) : slv_dat;

    wb_master_seq dut_a (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(a_cmd_valid), .cmd_ready_o(a_cmd_ready),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
        .rsp_dat_o(a_rsp_dat), .rsp_timeout_o(a_rsp_to),
        .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_we_o(a_we), .wbm_sel_o(a_sel),
        .wbm_adr_o(a_adr), .wbm_dat_o(a_dat), .wbm_ack_i(a_ack), .wbm_dat_i(a_slv_dat),
        .busy_o(a_busy)
    );

    wb_master_seq #(.TIMEOUT_CYCLES(4), .TO_W(16)) dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_dat_o(b_rsp_dat), .rsp_timeout_o(b_rsp_to),
        .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we), .wbm_sel_o(b_sel),
        .wbm_adr_o(b_adr), .wbm_dat_o(b_dat), .wbm_ack_i(b_ack), .wbm_dat_i(slv_dat),
        .busy_o(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and response log for the throughput test.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mon_en && a_rsp_valid && a_rsp_ready) begin
            rsp_log.push_back(a_rsp_dat);
            rsp_cyc.push_back(cycle);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int k;
        int guard;
        logic acc;
        n_checks = 0; n_errors = 0; cycle = 0; mon_en = 1'b0;
        rst_n = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0;
        slv_dat = 32'h0;
        a_cmd_valid = 1'b0; a_rsp_ready = 1'b0; a_ack_drv = 1'b0; a_zw = 1'b0;
        b_cmd_valid = 1'b0; b_rsp_ready = 1'b0; b_ack = 1'b0;

        // Reset held for 3 cycles
        repeat (3) tick();
        chk("rst_ctrl", {24'h0, a_cyc, a_stb, a_we, a_rsp_valid, a_rsp_to, a_busy, a_cmd_ready, 1'b0}, 32'h0);
        chk("rst_sel", {28'h0, a_sel}, 32'h0);
        chk("rst_adr", a_adr, 32'h0);
        chk("rst_dat", a_dat, 32'h0);
        chk("rst_rsp_dat", a_rsp_dat, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", {31'h0, a_cmd_ready}, 32'h1);
        chk("b_ready_after_rst", {31'h0, b_cmd_ready}, 32'h1);

        // Write to a zero-wait slave
        a_cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0004;
        cmd_dat = 32'hDEAD_BEEF; cmd_sel = 4'hF;
        tick();
        a_cmd_valid = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0; cmd_sel = 4'h0;
        chk("wr_cyc_stb_we", {29'h0, a_cyc, a_stb, a_we}, 32'h7);
        chk("wr_adr", a_adr, 32'h3000_0004);
        chk("wr_dat", a_dat, 32'hDEAD_BEEF);
        chk("wr_sel", {28'h0, a_sel}, 32'hF);
        chk("wr_ready_busy", {30'h0, a_cmd_ready, a_busy}, 32'h1);
        a_ack_drv = 1'b1; slv_dat = 32'h5555_AAAA;
        tick();
        a_ack_drv = 1'b0;
        chk("wr_cyc_drop", {31'h0, a_cyc}, 32'h0);
        chk("wr_rsp_valid", {31'h0, a_rsp_valid}, 32'h1);
        chk("wr_rsp_dat", a_rsp_dat, 32'h0);
        chk("wr_rsp_to", {31'h0, a_rsp_to}, 32'h0);
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        chk("wr_hs_valid", {31'h0, a_rsp_valid}, 32'h0);
        chk("wr_hs_ready_busy", {30'h0, a_cmd_ready, a_busy}, 32'h2);

        // Read with 5 wait states, response back-pressured for 3 cycles
        a_cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0008;
        tick();
        a_cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("rd_cyc_high", {30'h0, a_cyc, a_stb}, 32'h3);
            chk("rd_ready_low", {31'h0, a_cmd_ready}, 32'h0);
            chk("rd_adr_hold", a_adr, 32'h3000_0008);
            if (i == 5) begin
                a_ack_drv = 1'b1; slv_dat = 32'h1234_5678;
            end
            tick();
        end
        a_ack_drv = 1'b0; slv_dat = 32'hFFFF_FFFF;
        chk("rd_cyc_drop", {31'h0, a_cyc}, 32'h0);
        for (int j = 0; j < 3; j++) begin
            chk("rd_rsp_valid_hold", {31'h0, a_rsp_valid}, 32'h1);
            chk("rd_rsp_dat_hold", a_rsp_dat, 32'h1234_5678);
            chk("rd_rsp_to", {31'h0, a_rsp_to}, 32'h0);
            chk("rd_ready_low_resp", {31'h0, a_cmd_ready}, 32'h0);
            tick();
        end
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        chk("rd_hs", {30'h0, a_rsp_valid, a_cmd_ready}, 32'h1);

        // Timeout on instance b (TIMEOUT_CYCLES=4), no ack
        slv_dat = 32'hAAAA_5555; cmd_we = 1'b0; cmd_adr = 32'h3000_0100;
        b_cmd_valid = 1'b1;
        tick();
        b_cmd_valid = 1'b0;
        c = 0;
        while (b_cyc && c < 20) begin
            c++;
            tick();
        end
        chk("to_cyc_cycles", c, 32'd4);
        chk("to_rsp_valid", {31'h0, b_rsp_valid}, 32'h1);
        chk("to_rsp_to", {31'h0, b_rsp_to}, 32'h1);
        chk("to_rsp_dat", b_rsp_dat, 32'h0);
        b_rsp_ready = 1'b1;
        tick();
        b_rsp_ready = 1'b0;
        chk("to_hs", {30'h0, b_rsp_valid, b_cmd_ready}, 32'h1);

        // Ack on the 4th bus cycle coincides with expiry: ack wins
        b_cmd_valid = 1'b1;
        tick();
        b_cmd_valid = 1'b0;
        repeat (3) tick();
        chk("aw_cyc_still_high", {31'h0, b_cyc}, 32'h1);
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk("aw_cyc_drop", {31'h0, b_cyc}, 32'h0);
        chk("aw_rsp_valid", {31'h0, b_rsp_valid}, 32'h1);
        chk("aw_rsp_to", {31'h0, b_rsp_to}, 32'h0);
        chk("aw_rsp_dat", b_rsp_dat, 32'hAAAA_5555);
        b_rsp_ready = 1'b1;
        tick();
        b_rsp_ready = 1'b0;

        // Reset asserted in the 2nd bus cycle
        a_cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_000C;
        tick();
        a_cmd_valid = 1'b0;
        tick();
        chk("mr_cyc_before", {31'h0, a_cyc}, 32'h1);
        rst_n = 1'b0;
        tick();
        chk("mr_cyc_stb", {30'h0, a_cyc, a_stb}, 32'h0);
        chk("mr_busy_valid", {30'h0, a_busy, a_rsp_valid}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("mr_ready", {31'h0, a_cmd_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            a_ack_drv = (i == 0);
            tick();
            chk("mr_no_rsp", {30'h0, a_rsp_valid, a_cyc}, 32'h0);
        end
        a_ack_drv = 1'b0;
        a_cmd_valid = 1'b1; cmd_adr = 32'h3000_0010;
        tick();
        a_cmd_valid = 1'b0;
        a_ack_drv = 1'b1; slv_dat = 32'hCAFE_F00D;
        tick();
        a_ack_drv = 1'b0;
        chk("mr_rd_valid", {30'h0, a_rsp_valid, a_rsp_to}, 32'h2);
        chk("mr_rd_dat", a_rsp_dat, 32'hCAFE_F00D);
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;

        // Stray ack while idle
        a_ack_drv = 1'b1;
        repeat (2) tick();
        a_ack_drv = 1'b0;
        tick();
        chk("stray_no_rsp", {29'h0, a_rsp_valid, a_cyc, a_busy}, 32'h0);
        chk("stray_ready", {31'h0, a_cmd_ready}, 32'h1);

        // Four back-to-back reads to a zero-wait slave
        a_zw = 1'b1; a_rsp_ready = 1'b1; mon_en = 1'b1;
        cmd_we = 1'b0; cmd_adr = 32'h3000_0200; a_cmd_valid = 1'b1;
        k = 0; guard = 0;
        while (k < 4 && guard < 40) begin
            acc = a_cmd_ready;
            tick();
            guard++;
            if (acc) begin
                k++;
                cmd_adr = 32'h3000_0200 + 32'(4 * k);
                if (k == 4) a_cmd_valid = 1'b0;
            end
        end
        a_cmd_valid = 1'b0;
        repeat (4) tick();
        mon_en = 1'b0;
        chk("b2b_accepts", k, 32'd4);
        chk("b2b_rsp_count", rsp_log.size(), 32'd4);
        for (int i = 0; i < rsp_log.size() && i < 4; i++) begin
            chk("b2b_rsp_dat", rsp_log[i], (32'h3000_0200 + 32'(4 * i)) ^ 32'hA5A5_0000);
            if (i > 0) chk("b2b_period", rsp_cyc[i] - rsp_cyc[i-1], 32'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
